// File: rtl/mbr_pkg.sv
// Shared word-size definitions for the memory buffer, so every CPU-side user
// agrees on the width of a buffered word.
package mbr_pkg;
   localparam int MBR_DATA_WIDTH = 16;

   typedef logic [MBR_DATA_WIDTH-1:0] mbr_word_t;
endpackage

// File: rtl/mbr_occupancy_ctrl.sv
// Pointer, occupancy and flush bookkeeping for the memory buffer FIFO.
// The storage array lives in the parent; this block only says where and when to write or read.
module mbr_occupancy_ctrl
   import mbr_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   input  logic             out_ready_i,
   output logic             wr_en_o,
   output logic [PTR_W-1:0] wr_ptr_o,
   output logic [PTR_W-1:0] rd_ptr_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_w, empty_w, push_w, pop_w;

   // full/empty come only from registered count, so in_ready never depends on out_ready
   assign full_w  = (count_q == CNT_W'(DEPTH));
   assign empty_w = (count_q == '0);
   assign push_w  = in_valid_i && !full_w;
   assign pop_w   = out_ready_i && !empty_w;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_w) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_en_o  = push_w && !flush_i;
   assign wr_ptr_o = wr_ptr_q;
   assign rd_ptr_o = rd_ptr_q;
   assign count_o  = count_q;
   assign full_o   = full_w;
   assign empty_o  = empty_w;

   a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));
   a_count_min: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(pop_w && !push_w && count_q == '0));

endmodule

// File: rtl/memory_buffer_fifo.sv
// DEPTH-entry valid/ready buffer between the memory bus and the CPU datapath,
// with occupancy reporting and synchronous flush.
module memory_buffer_fifo
   import mbr_pkg::*;
#(
   parameter  int DATA_WIDTH = MBR_DATA_WIDTH,
   parameter  int DEPTH      = 4,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] data_input,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] data_output,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  wr_en_w;
   logic [PTR_W-1:0]      wr_ptr_w, rd_ptr_w;

   mbr_occupancy_ctrl #(
      .DEPTH (DEPTH)
   ) u_occ (
      .clk         (clk),
      .rst_n       (reset),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .out_ready_i (out_ready),
      .wr_en_o     (wr_en_w),
      .wr_ptr_o    (wr_ptr_w),
      .rd_ptr_o    (rd_ptr_w),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en_w) begin
         mem_q[wr_ptr_w] <= data_input;
      end
   end

   assign in_ready  = !full;
   assign out_valid = !empty;
   // Masking hides entries left behind by a flush.
   assign data_output = out_valid ? mem_q[rd_ptr_w] : '0;

endmodule

// File: tb/tb_memory_buffer_fifo.sv
// Directed bench for memory_buffer_fifo (DEPTH=4, DATA_WIDTH=16).
module tb_memory_buffer_fifo;
   import mbr_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   mbr_word_t       data_input;
   logic            in_valid;
   logic            in_ready;
   mbr_word_t       data_output;
   logic            out_valid;
   logic            out_ready;
   logic [2:0]      count;
   logic            full;
   logic            empty;

   int n_tests = 0;
   int n_fail  = 0;

   memory_buffer_fifo #(.DATA_WIDTH(16), .DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .data_input  (data_input),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .data_output (data_output),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [15:0] din, input logic ordy, input logic fl);
      in_valid   = iv;
      data_input = din;
      out_ready  = ordy;
      flush      = fl;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_ovalid"}, 32'(out_valid), 0);
      chk({tag, "_iready"}, 32'(in_ready), 1);
      chk({tag, "_dout"}, 32'(data_output), 0);
   endtask

   initial begin
      reset      = 1'b0;
      flush      = 1'b0;
      data_input = 16'd1234;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      #1;
      chk_idle("rst");
      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 16'd1234, 1'b0, 1'b0);
      chk_idle("rst_rel");

      // two pushes then a pop
      step(1'b1, 16'd1234, 1'b0, 1'b0);
      chk("t2_cnt1", 32'(count), 1);
      chk("t2_dout1", 32'(data_output), 32'h04D2);
      step(1'b1, 16'd5678, 1'b0, 1'b0);
      chk("t2_cnt2", 32'(count), 2);
      chk("t2_dout2", 32'(data_output), 32'h04D2);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t2_dout3", 32'(data_output), 32'h162E);
      chk("t2_cnt3", 32'(count), 1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_idle("t2_end");

      // fill to full, overflow push ignored, drain in order
      for (int k = 1; k <= 4; k++) step(1'b1, 16'(k), 1'b0, 1'b0);
      chk("t3_cnt", 32'(count), 4);
      chk("t3_full", 32'(full), 1);
      chk("t3_iready", 32'(in_ready), 0);
      out_ready = 1'b1;
      #1;
      chk("t3_iready_nopass", 32'(in_ready), 0);
      out_ready = 1'b0;
      step(1'b1, 16'h0005, 1'b0, 1'b0);
      chk("t3_ovf_cnt", 32'(count), 4);
      chk("t3_ovf_head", 32'(data_output), 1);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("t3_pop%0d", k), 32'(data_output), 32'(k));
         step(1'b0, 16'h0000, 1'b1, 1'b0);
      end
      chk_idle("t3_end");

      // wrap-around, twice through three entries
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h000A + 3 * r + k), 1'b0, 1'b0);
         chk($sformatf("t4_cnt_r%0d", r), 32'(count), 3);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_pop_r%0d_%0d", r, k), 32'(data_output), 32'(32'h000A + 3 * r + k));
            step(1'b0, 16'h0000, 1'b1, 1'b0);
         end
         chk($sformatf("t4_empty_r%0d", r), 32'(empty), 1);
      end

      // simultaneous push and pop at count 2
      step(1'b1, 16'h0021, 1'b0, 1'b0);
      step(1'b1, 16'h0022, 1'b0, 1'b0);
      chk("t5_cnt_pre", 32'(count), 2);
      step(1'b1, 16'h0023, 1'b1, 1'b0);
      chk("t5_cnt", 32'(count), 2);
      chk("t5_head", 32'(data_output), 32'h0022);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t5_tail", 32'(data_output), 32'h0023);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t5_empty", 32'(empty), 1);

      // flush beats push and pop
      step(1'b1, 16'h0031, 1'b0, 1'b0);
      step(1'b1, 16'h0032, 1'b0, 1'b0);
      step(1'b1, 16'h0033, 1'b0, 1'b0);
      chk("t6_cnt3", 32'(count), 3);
      step(1'b1, 16'hBEEF, 1'b1, 1'b1);
      chk_idle("t6_flush");
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("t6_still_empty", 32'(count), 0);
      step(1'b1, 16'h0044, 1'b0, 1'b0);
      chk("t6_after_head", 32'(data_output), 32'h0044);
      chk("t6_after_cnt", 32'(count), 1);
      step(1'b1, 16'h0045, 1'b0, 1'b0);
      chk("t6_after_cnt2", 32'(count), 2);

      // asynchronous reset between edges
      #2;
      reset = 1'b0;
      #1;
      chk_idle("t6_async");
      @(negedge clk);
      reset = 1'b1;
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      chk_idle("t6_rel");
      step(1'b1, 16'h0055, 1'b0, 1'b0);
      chk("t6_post_head", 32'(data_output), 32'h0055);
      chk("t6_post_cnt", 32'(count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
